// File: rtl/sm_phase_seq.sv
// sm_phase_seq: stepper coil-phase sequencer with absolute position, travel limits
// and an idle hold-current request.
module sm_phase_seq #(
    parameter int POS_W       = 32,
    parameter int HOLD_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step_in,
    input  logic                    dir,
    input  logic                    half_step,
    input  logic                    drv_en,
    input  logic                    lim_fwd,
    input  logic                    lim_rev,
    input  logic                    pos_clr,
    output logic [3:0]              phase,
    output logic signed [POS_W-1:0] pos,
    output logic                    moving,
    output logic                    hold_low,
    output logic                    step_rej
);
    localparam int CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [3:0] PHASE_TBL [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                             4'b0100, 4'b1100, 4'b1000, 4'b1001};
    typedef enum logic [1:0] {OFF, RUN, HOLD} state_t;
    state_t           state, nxt_state;
    logic [2:0]       idx, nxt_idx, stride;
    logic [CNT_W-1:0] idle_cnt;
    logic             step_d, live, blocked, acc;
    // Full-step from an odd (half) position only moves to the adjacent full position.
    always_comb begin
        live      = step_in & ~step_d & (state != OFF) & drv_en;
        blocked   = dir ? lim_fwd : lim_rev;
        acc       = live & ~blocked;
        stride    = (half_step | idx[0]) ? 3'd1 : 3'd2;
        nxt_idx   = acc ? (dir ? idx + stride : idx - stride) : idx;
        nxt_state = !drv_en ? OFF
                  : (state == OFF || acc) ? RUN
                  : (state == RUN && idle_cnt == CNT_W'(HOLD_CYCLES - 1)) ? HOLD
                  : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OFF;
            idx      <= '0;
            idle_cnt <= '0;
            step_d   <= 1'b1;
            phase    <= '0;
            pos      <= '0;
            moving   <= 1'b0;
            hold_low <= 1'b0;
            step_rej <= 1'b0;
        end else begin
            state    <= nxt_state;
            idx      <= nxt_idx;
            step_d   <= step_in;
            idle_cnt <= (acc || state != RUN) ? '0 : idle_cnt + 1'b1;
            pos      <= pos_clr ? '0 : !acc ? pos : dir ? pos + POS_W'(stride) : pos - POS_W'(stride);
            phase    <= (nxt_state == OFF) ? 4'b0000 : PHASE_TBL[nxt_idx];
            moving   <= nxt_state == RUN;
            hold_low <= nxt_state == HOLD;
            step_rej <= live & blocked;
        end
    end
endmodule

// File: tb/tb_sm_phase_seq.sv
// tb_sm_phase_seq: directed scenarios plus randomized traffic against a
// behavioural model of the phase sequencer.
module tb_sm_phase_seq;
    localparam int HOLD = 16;
    localparam int S_OFF = 0, S_RUN = 1, S_HOLD = 2;
    localparam logic [3:0] TBL [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                       4'b0100, 4'b1100, 4'b1000, 4'b1001};
    logic clk = 0, rst = 1, step_in = 0, dir = 0, half_step = 0, drv_en = 0;
    logic lim_fwd = 0, lim_rev = 0, pos_clr = 0;
    logic [3:0] phase, phase4, pos4;
    logic signed [31:0] pos;
    logic moving, hold_low, step_rej, moving4, hold4, rej4;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    sm_phase_seq #(.POS_W(32), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .step_in(step_in), .dir(dir), .half_step(half_step),
        .drv_en(drv_en), .lim_fwd(lim_fwd), .lim_rev(lim_rev), .pos_clr(pos_clr),
        .phase(phase), .pos(pos), .moving(moving), .hold_low(hold_low), .step_rej(step_rej));

    sm_phase_seq #(.POS_W(4), .HOLD_CYCLES(HOLD)) dut4 (
        .clk(clk), .rst(rst), .step_in(step_in), .dir(dir), .half_step(half_step),
        .drv_en(drv_en), .lim_fwd(lim_fwd), .lim_rev(lim_rev), .pos_clr(pos_clr),
        .phase(phase4), .pos(pos4), .moving(moving4), .hold_low(hold4), .step_rej(rej4));

    // Reference: position kept as an unbounded integer, idle time as cycles since last step.
    typedef struct {int st; int idx; int quiet; longint pos; bit rej; bit prev;} model_t;
    model_t m = '{0, 0, 0, 0, 0, 1};

    function automatic model_t next_model(model_t c);
        model_t n = c;
        int s;
        bit rising = step_in && !c.prev;
        n.rej = 0;
        n.prev = step_in;
        if (rst) begin
            n.st = S_OFF; n.idx = 0; n.quiet = 0; n.pos = 0; n.prev = 1;
            return n;
        end
        if (!drv_en) n.st = S_OFF;
        else if (c.st == S_OFF) begin
            n.st = S_RUN; n.quiet = 0;
        end else if (rising && !(dir ? lim_fwd : lim_rev)) begin
            s = (half_step || c.idx % 2 == 1) ? 1 : 2;
            n.idx = (c.idx + (dir ? s : 8 - s)) % 8;
            n.pos = c.pos + (dir ? s : -s);
            n.st = S_RUN; n.quiet = 0;
        end else begin
            n.rej = rising;
            if (c.st == S_RUN) begin
                n.quiet = c.quiet + 1;
                if (n.quiet >= HOLD) n.st = S_HOLD;
            end
        end
        if (pos_clr) n.pos = 0;
        return n;
    endfunction

    always @(posedge clk) m <= next_model(m);

    function automatic logic [3:0] m_phase();
        return (m.st == S_OFF) ? 4'b0000 : TBL[m.idx];
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        step_in = 1; tick(1); step_in = 0; tick(1);
    endtask

    task automatic do_reset();
        rst = 1; step_in = 0; pos_clr = 0; lim_fwd = 0; lim_rev = 0;
        tick(2);
        rst = 0;
    endtask

    task automatic test_reset();
        drv_en = 1; dir = 1; half_step = 1; rst = 1; step_in = 1;
        tick(3);
        checks++;
        if ({phase, moving, hold_low, step_rej} !== 7'b0) begin
            errors++; $display("FAIL reset_outs got %b want 0000000", {phase, moving, hold_low, step_rej});
        end
        checks++;
        if (pos !== 0) begin errors++; $display("FAIL reset_pos got %0h want 0", pos); end
        rst = 0;
        tick(1);
        checks++;
        if (phase !== 4'b0001 || moving !== 1'b1) begin
            errors++; $display("FAIL reset_run got %b/%b want 0001/1", phase, moving);
        end
        tick(1);
        checks++;
        if (pos !== 0) begin errors++; $display("FAIL reset_held_step got %0h want 0", pos); end
        step_in = 0;
    endtask

    task automatic test_half_step();
        logic [3:0] want [3] = '{4'b0011, 4'b0010, 4'b0110};
        drv_en = 1; half_step = 1; dir = 1;
        do_reset();
        tick(1);
        for (int i = 0; i < 3; i++) begin
            pulse();
            checks++;
            if (phase !== want[i]) begin
                errors++; $display("FAIL half_phase%0d got %b want %b", i, phase, want[i]);
            end
        end
        checks++;
        if (pos !== 3 || moving !== 1'b1) begin
            errors++; $display("FAIL half_pos got %0d/%b want 3/1", pos, moving);
        end
    endtask

    task automatic test_full_step();
        logic [3:0] want_ph [4] = '{4'b1000, 4'b0100, 4'b1100, 4'b1000};
        logic [31:0] want_pos [4] = '{32'hFFFFFFFE, 32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFE};
        logic hs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic dr [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        drv_en = 1;
        do_reset();
        tick(1);
        for (int i = 0; i < 4; i++) begin
            half_step = hs[i]; dir = dr[i];
            pulse();
            checks++;
            if (phase !== want_ph[i] || pos !== want_pos[i]) begin
                errors++; $display("FAIL full_step%0d got %b/%h want %b/%h", i, phase, pos, want_ph[i], want_pos[i]);
            end
        end
    endtask

    task automatic test_limits();
        half_step = 1; lim_fwd = 1; dir = 1; step_in = 1;
        tick(1);
        checks++;
        if (step_rej !== 1'b1 || phase !== 4'b1000 || pos !== -2) begin
            errors++; $display("FAIL lim_fwd_rej got %b/%b/%0d want 1/1000/-2", step_rej, phase, pos);
        end
        step_in = 0;
        tick(1);
        checks++;
        if (step_rej !== 1'b0) begin errors++; $display("FAIL lim_rej_pulse got %b want 0", step_rej); end
        dir = 0; step_in = 1;
        tick(1);
        checks++;
        if (step_rej !== 1'b0 || phase !== 4'b1100 || pos !== -3) begin
            errors++; $display("FAIL lim_fwd_rev_ok got %b/%b/%0d want 0/1100/-3", step_rej, phase, pos);
        end
        step_in = 0; lim_fwd = 0; lim_rev = 1;
        tick(1);
        step_in = 1;
        tick(1);
        checks++;
        if (step_rej !== 1'b1 || pos !== -3) begin
            errors++; $display("FAIL lim_rev_rej got %b/%0d want 1/-3", step_rej, pos);
        end
        step_in = 0; dir = 1;
        tick(1);
        pulse();
        checks++;
        if (phase !== 4'b1000 || pos !== -2) begin
            errors++; $display("FAIL lim_rev_fwd_ok got %b/%0d want 1000/-2", phase, pos);
        end
        lim_rev = 0;
    endtask

    task automatic test_hold();
        half_step = 1; dir = 1;
        pulse();
        tick(14);
        checks++;
        if (hold_low !== 1'b0 || moving !== 1'b1) begin
            errors++; $display("FAIL hold_early got %b/%b want 0/1", hold_low, moving);
        end
        tick(1);
        checks++;
        if (hold_low !== 1'b1 || moving !== 1'b0 || phase !== 4'b1001) begin
            errors++; $display("FAIL hold_enter got %b/%b/%b want 1/0/1001", hold_low, moving, phase);
        end
        step_in = 1;
        tick(1);
        checks++;
        if (hold_low !== 1'b0 || moving !== 1'b1 || phase !== 4'b0001 || pos !== 0) begin
            errors++; $display("FAIL hold_exit got %b/%b/%b/%0d want 0/1/0001/0", hold_low, moving, phase, pos);
        end
        step_in = 0;
        tick(1);
    endtask

    task automatic test_wrap_clr();
        drv_en = 1; half_step = 1; dir = 1;
        do_reset();
        tick(1);
        repeat (15) pulse();
        checks++;
        if (pos4 !== 4'hF || pos !== 15) begin
            errors++; $display("FAIL wrap15 got %h/%0d want f/15", pos4, pos);
        end
        pulse();
        checks++;
        if (pos4 !== 4'h0 || pos !== 16) begin
            errors++; $display("FAIL wrap16 got %h/%0d want 0/16", pos4, pos);
        end
        step_in = 1; pos_clr = 1;
        tick(1);
        step_in = 0; pos_clr = 0;
        checks++;
        if (pos !== 0 || pos4 !== 0 || phase !== 4'b0011) begin
            errors++; $display("FAIL clr_step got %0d/%h/%b want 0/0/0011", pos, pos4, phase);
        end
        tick(1);
    endtask

    task automatic test_disable_rst();
        half_step = 1; dir = 1;
        pulse();
        drv_en = 0; step_in = 1;
        tick(1);
        checks++;
        if (phase !== 4'b0000 || moving !== 1'b0 || step_rej !== 1'b0 || pos !== 1) begin
            errors++; $display("FAIL dis_off got %b/%b/%b/%0d want 0000/0/0/1", phase, moving, step_rej, pos);
        end
        step_in = 0; lim_fwd = 1;
        tick(1);
        step_in = 1;
        tick(1);
        checks++;
        if (step_rej !== 1'b0) begin errors++; $display("FAIL dis_no_rej got %b want 0", step_rej); end
        step_in = 0; lim_fwd = 0;
        tick(1);
        pulse();
        checks++;
        if (pos !== 1 || phase !== 4'b0000) begin
            errors++; $display("FAIL dis_ignored got %0d/%b want 1/0000", pos, phase);
        end
        drv_en = 1;
        tick(1);
        checks++;
        if (phase !== 4'b0010 || moving !== 1'b1) begin
            errors++; $display("FAIL dis_reenable got %b/%b want 0010/1", phase, moving);
        end
        pulse(); pulse();
        step_in = 1; rst = 1;
        tick(1);
        checks++;
        if (phase !== 4'b0000 || pos !== 0 || moving !== 1'b0) begin
            errors++; $display("FAIL mid_rst got %b/%0d/%b want 0000/0/0", phase, pos, moving);
        end
        rst = 0; step_in = 0;
        tick(1);
    endtask

    task automatic test_random();
        int unsigned dens = 1;
        drv_en = 1;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            tick(1);
            checks++;
            if (phase !== m_phase() || pos !== 32'(m.pos) || moving !== (m.st == S_RUN)
                || hold_low !== (m.st == S_HOLD) || step_rej !== m.rej) begin
                errors++;
                $display("FAIL rand_main cyc %0d got %b/%h/%b%b%b want %b/%h/%b%b%b", i, phase, pos,
                         moving, hold_low, step_rej, m_phase(), 32'(m.pos), m.st == S_RUN, m.st == S_HOLD, m.rej);
            end
            checks++;
            if ({phase4, pos4, moving4, hold4, rej4} !== {m_phase(), 4'(m.pos), m.st == S_RUN, m.st == S_HOLD, m.rej}) begin
                errors++;
                $display("FAIL rand_pos4 cyc %0d got %b/%h want %b/%h", i, phase4, pos4, m_phase(), 4'(m.pos));
            end
            if (i % 200 == 0) dens = $urandom_range(0, 2);
            step_in   = (dens != 0) && ($urandom_range(0, 3) < dens);
            dir       = 1'($urandom_range(0, 1));
            half_step = 1'($urandom_range(0, 1));
            drv_en    = $urandom_range(0, 59) != 0;
            lim_fwd   = $urandom_range(0, 7) == 0;
            lim_rev   = $urandom_range(0, 7) == 0;
            pos_clr   = $urandom_range(0, 99) == 0;
            rst       = $urandom_range(0, 1499) == 0;
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_half_step();
        test_full_step();
        test_limits();
        test_hold();
        test_wrap_clr();
        test_disable_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
